// File: rtl/union_pack_fifo_pkg.sv
// Shared types and defaults for the union-packing FIFO.
package union_pack_pkg;

  typedef enum logic {
    MODE_WORD = 1'b0,
    MODE_LANE = 1'b1
  } mode_e;

  localparam int LANES_DEF  = 4;
  localparam int LANE_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  localparam logic [15:0] SATURATE_MAX = 16'hFFFF;

endpackage

// File: rtl/union_pack_fifo_mem.sv
// DEPTH-entry ring buffer holding {union word, lane count}; head data reads 0 when empty.
module union_pack_fifo_mem
  import union_pack_pkg::*;
#(
  parameter int ENTRY_W = 35,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ENTRY_W-1:0]         wdata,
  output logic [ENTRY_W-1:0]         rdata,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      level <= level + LVL_W'(1);
      else if (do_pop && !do_push) level <= level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/union_pack_fifo.sv
// Packs lane beats LSB-first (or whole-word beats) into union entries and queues them.
// Optional partial-commit counter enabled by defining UNION_PACK_FIFO_STATS_EN.
module union_pack_fifo
  import union_pack_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int WORD_W = LANES*LANE_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_mode,
  input  logic [WORD_W-1:0]          in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W-1:0]          out_word,
  output logic [$clog2(LANES+1)-1:0] out_lanes,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [15:0]                partial_cnt
);

  localparam int CNT_W   = $clog2(LANES+1);
  localparam int ACC_W   = $clog2(LANES);
  localparam int ENTRY_W = WORD_W + CNT_W;

  typedef union packed {
    logic [WORD_W-1:0]             word;
    logic [LANES-1:0][LANE_W-1:0]  lane;
  } word_u;

  word_u              acc;
  word_u              acc_nxt;
  word_u              push_word;
  logic [ACC_W-1:0]   acc_cnt;
  logic [CNT_W-1:0]   push_lanes;
  logic [ENTRY_W-1:0] head;
  logic               full;
  logic               empty;
  logic               fill;
  logic               is_word;
  logic               accept;
  logic               flush;
  logic               lane_last;
  logic               push;

  assign fill      = (acc_cnt != '0);
  assign is_word   = (mode_e'(in_mode) == MODE_WORD);
  assign in_ready  = rst_n && !full && !(is_word && fill);
  assign accept    = in_valid && in_ready;
  assign flush     = in_valid && is_word && fill && !full;
  assign lane_last = (acc_cnt == ACC_W'(LANES-1)) || in_last;

  always_comb begin
    acc_nxt              = acc;
    acc_nxt.lane[acc_cnt] = in_data[LANE_W-1:0];
    push                 = 1'b0;
    push_word            = acc;
    push_lanes           = CNT_W'(acc_cnt);
    if (flush) begin
      push = 1'b1;
    end else if (accept && is_word) begin
      push           = 1'b1;
      push_word.word = in_data;
      push_lanes     = CNT_W'(LANES);
    end else if (accept && lane_last) begin
      push       = 1'b1;
      push_word  = acc_nxt;
      push_lanes = CNT_W'(acc_cnt) + CNT_W'(1);
    end
  end

  // Clearing on every commit keeps lanes above the next count at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (push) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (accept && !is_word) begin
      acc     <= acc_nxt;
      acc_cnt <= acc_cnt + ACC_W'(1);
    end
  end

  union_pack_fifo_mem #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (out_ready),
    .wdata ({push_word, push_lanes}),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_word  = head[ENTRY_W-1:CNT_W];
  assign out_lanes = head[CNT_W-1:0];

`ifdef UNION_PACK_FIFO_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == SATURATE_MAX) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      partial_cnt <= '0;
    end else if (push && (push_lanes != CNT_W'(LANES))) begin
      partial_cnt <= sat_inc(partial_cnt);
    end
  end
`else
  assign partial_cnt = '0;
`endif

endmodule

// File: tb/tb_union_pack_fifo.sv
// Directed and randomized bench for union_pack_fifo against a queue-based reference model.
module tb_union_pack_fifo;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int DEPTH  = 4;
  localparam int WORD_W = LANES*LANE_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_word;
  logic [2:0]        out_lanes;
  logic [2:0]        level;
  logic [15:0]       partial_cnt;

  int tests = 0;
  int fails = 0;

  logic [WORD_W-1:0] qw[$];
  int                qn[$];
  logic [LANE_W-1:0] acc_lane[LANES];
  int                acc_n = 0;
  int                pcnt  = 0;

  always #5 clk = ~clk;

  union_pack_fifo #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mode     (in_mode),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_word    (out_word),
    .out_lanes   (out_lanes),
    .level       (level),
    .partial_cnt (partial_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_pcnt();
`ifdef UNION_PACK_FIFO_STATS_EN
    return (pcnt > 65535) ? 65535 : pcnt;
`else
    return 0;
`endif
  endfunction

  function automatic logic [WORD_W-1:0] acc_word();
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < acc_n; i++) w = w | (WORD_W'(acc_lane[i]) << (i*LANE_W));
    return w;
  endfunction

  task automatic model_commit();
    qw.push_back(acc_word());
    qn.push_back(acc_n);
    if (acc_n < LANES) pcnt++;
    acc_n = 0;
  endtask

  task automatic model_reset();
    qw.delete();
    qn.delete();
    acc_n = 0;
    pcnt  = 0;
  endtask

  task automatic check_all();
    logic full;
    logic exp_rdy;
    logic [WORD_W-1:0] exp_word;
    int exp_lanes;
    full      = (qw.size() == DEPTH);
    exp_rdy   = !full && !(in_mode == 1'b0 && acc_n > 0);
    exp_word  = (qw.size() > 0) ? qw[0] : '0;
    exp_lanes = (qn.size() > 0) ? qn[0] : 0;
    chk("in_ready",    64'(in_ready),    64'(exp_rdy));
    chk("out_valid",   64'(out_valid),   64'(qw.size() > 0));
    chk("out_word",    64'(out_word),    64'(exp_word));
    chk("out_lanes",   64'(out_lanes),   64'(exp_lanes));
    chk("level",       64'(level),       64'(qw.size()));
    chk("partial_cnt", 64'(partial_cnt), 64'(exp_pcnt()));
  endtask

  task automatic model_step();
    logic full;
    logic rdy;
    full = (qw.size() == DEPTH);
    rdy  = !full && !(in_mode == 1'b0 && acc_n > 0);
    if (out_ready && qw.size() > 0) begin
      void'(qw.pop_front());
      void'(qn.pop_front());
    end
    if (in_valid && rdy && in_mode == 1'b1) begin
      acc_lane[acc_n] = in_data[LANE_W-1:0];
      acc_n++;
      if (acc_n == LANES || in_last) model_commit();
    end else if (in_valid && rdy) begin
      qw.push_back(in_data);
      qn.push_back(LANES);
    end else if (in_valid && in_mode == 1'b0 && acc_n > 0 && !full) begin
      model_commit();
    end
  endtask

  task automatic cyc(input logic v, input logic m, input logic [WORD_W-1:0] d,
                     input logic l, input logic r);
    in_valid  = v;
    in_mode   = m;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    #4;
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_level",    64'(level),    64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, '0, 0, 1);

    // Single word beat, then pop
    cyc(1, 0, 32'hDEADBEEF, 0, 1);
    chk("tp1_word",  64'(out_word),  64'hDEADBEEF);
    chk("tp1_lanes", 64'(out_lanes), 64'd4);
    chk("tp1_level", 64'(level),     64'd1);
    cyc(0, 0, '0, 0, 1);
    chk("tp1_drain", 64'(level), 64'd0);

    // Four lane beats fill a word
    cyc(1, 1, 32'h11, 0, 0);
    cyc(1, 1, 32'h22, 0, 0);
    cyc(1, 1, 32'h33, 0, 0);
    cyc(1, 1, 32'h44, 0, 0);
    chk("tp2_word",  64'(out_word),  64'h44332211);
    chk("tp2_lanes", 64'(out_lanes), 64'd4);
    cyc(0, 0, '0, 0, 1);

    // Short lane packet with in_last
    cyc(1, 1, 32'hFFFFFFAA, 0, 0);
    cyc(1, 1, 32'h000000BB, 1, 0);
    chk("tp3_word",  64'(out_word),  64'h0000BBAA);
    chk("tp3_lanes", 64'(out_lanes), 64'd2);
    cyc(0, 0, '0, 0, 1);

    // Word beat while filling forces a flush first
    cyc(1, 1, 32'h5A, 0, 1);
    cyc(1, 0, 32'h12345678, 0, 0);
    chk("tp4_flush_word",  64'(out_word),  64'h5A);
    chk("tp4_flush_lanes", 64'(out_lanes), 64'd1);
    cyc(1, 0, 32'h12345678, 0, 1);
    chk("tp4_word",  64'(out_word),  64'h12345678);
    chk("tp4_lanes", 64'(out_lanes), 64'd4);
    cyc(0, 0, '0, 0, 1);

    // Fill to DEPTH, hold the fifth, then pop once and wrap
    for (int i = 0; i < 5; i++) cyc(1, 0, 32'hA000_0000 + i, 0, 0);
    chk("tp5_level", 64'(level), 64'd4);
    cyc(1, 0, 32'hA000_0004, 0, 1);
    cyc(1, 0, 32'hA000_0004, 0, 0);
    chk("tp5_wrap_level", 64'(level), 64'd4);
    for (int i = 0; i < 5; i++) cyc(0, 0, '0, 0, 1);

    // Asynchronous reset mid-accumulation
    cyc(1, 0, 32'h77, 0, 0);
    cyc(1, 1, 32'h01, 0, 0);
    cyc(1, 1, 32'h02, 0, 0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid),   64'd0);
    chk("ar_out_word",  64'(out_word),    64'd0);
    chk("ar_out_lanes", 64'(out_lanes),   64'd0);
    chk("ar_level",     64'(level),       64'd0);
    chk("ar_in_ready",  64'(in_ready),    64'd0);
    chk("ar_partial",   64'(partial_cnt), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, 0, 32'hCAFEF00D, 0, 0);
    chk("ar_word",  64'(out_word),  64'hCAFEF00D);
    chk("ar_lanes", 64'(out_lanes), 64'd4);
    chk("ar_level_after", 64'(level), 64'd1);
    cyc(0, 0, '0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom,
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 6; i++) cyc(0, 0, '0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
